// File: rtl/adc_pkg.sv
// Shared definitions for the ADC line capture block: FSM encoding, the format
// conversion mask and the averaging-exponent clamp.
package adc_pkg;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    // XOR mask that flips only the MSB of a width-bit sample (offset-binary to two's complement).
    function automatic logic [63:0] msb_mask(input int unsigned width);
        return 64'(1) << (width - 1);
    endfunction

    function automatic int unsigned clamp_avg(input int unsigned req, input int unsigned max_log2);
        return (req > max_log2) ? max_log2 : req;
    endfunction

endpackage

// File: rtl/adc_fmt_stage.sv
// Free-running input pipeline: IOB capture of the ADC bus, optional MSB inversion
// and detection of raw samples sitting at either rail.
module adc_fmt_stage
    import adc_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              fmt_signed_i,
    output logic [DATA_W-1:0] conv_o,
    output logic              raw_clip_o
);

    localparam logic [DATA_W-1:0] MSB_MASK = DATA_W'(msb_mask(DATA_W));

    logic [DATA_W-1:0] iob_q;
    logic [DATA_W-1:0] conv_q;
    logic              raw_clip_q;

    // Clip is judged on the raw pins so it is independent of the output format.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            iob_q      <= '0;
            conv_q     <= '0;
            raw_clip_q <= 1'b0;
        end else begin
            iob_q      <= data_i;
            conv_q     <= iob_q ^ (fmt_signed_i ? MSB_MASK : '0);
            raw_clip_q <= (iob_q == '0) || (iob_q == '1);
        end
    end

    assign conv_o     = conv_q;
    assign raw_clip_o = raw_clip_q;

endmodule

// File: rtl/adc_line_capture.sv
// Line framing, box-car averaging over 2^k samples and the IDLE/ACTIVE control FSM
// for the ADC front end; emits one strobed pixel per averaging window.
module adc_line_capture
    import adc_pkg::*;
#(
    parameter  int DATA_W       = 12,
    parameter  int AVG_MAX_LOG2 = 3,
    parameter  int PIX_W        = 12,
    localparam int AVG_W        = $clog2(AVG_MAX_LOG2 + 1)
) (
    input  logic              adc_clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] adc_data_i,
    input  logic              fmt_signed_i,
    input  logic [AVG_W-1:0]  avg_log2_i,
    input  logic [PIX_W-1:0]  line_len_i,
    input  logic              line_start_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              dvalid_o,
    output logic [PIX_W-1:0]  pix_idx_o,
    output logic              line_busy_o,
    output logic              line_done_o,
    output logic              clip_o
);

    localparam int ACC_W = DATA_W + AVG_MAX_LOG2;
    localparam int CNT_W = (AVG_MAX_LOG2 > 0) ? AVG_MAX_LOG2 : 1;

    logic [DATA_W-1:0] conv;
    logic              raw_clip;

    adc_fmt_stage #(
        .DATA_W(DATA_W)
    ) u_fmt (
        .clk_i       (adc_clk_i),
        .rst_i       (rst_i),
        .data_i      (adc_data_i),
        .fmt_signed_i(fmt_signed_i),
        .conv_o      (conv),
        .raw_clip_o  (raw_clip)
    );

    state_e             state_q, state_d;
    logic               fmt_q, fmt_d;
    logic [AVG_W-1:0]   avg_q, avg_d;
    logic [PIX_W-1:0]   len_q, len_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               dvalid_q, dvalid_d;
    logic [PIX_W-1:0]   pix_idx_q, pix_idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               zero_pend_q, zero_pend_d;
    logic               clip_q, clip_d;

    logic [ACC_W-1:0]        sample_ext;
    logic [ACC_W-1:0]        sum;
    logic signed [ACC_W-1:0] sum_s;
    logic [ACC_W-1:0]        shifted;
    logic [CNT_W-1:0]        win_max;

    always_ff @(posedge adc_clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            fmt_q       <= 1'b0;
            avg_q       <= '0;
            len_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            pix_cnt_q   <= '0;
            dout_q      <= '0;
            dvalid_q    <= 1'b0;
            pix_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            zero_pend_q <= 1'b0;
            clip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fmt_q       <= fmt_d;
            avg_q       <= avg_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            dout_q      <= dout_d;
            dvalid_q    <= dvalid_d;
            pix_idx_q   <= pix_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            zero_pend_q <= zero_pend_d;
            clip_q      <= clip_d;
        end
    end

    // A zero-length line still owes the consumer a LINE_DONE, delayed one cycle via zero_pend.
    always_comb begin
        state_d     = state_q;
        fmt_d       = fmt_q;
        avg_d       = avg_q;
        len_d       = len_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        pix_cnt_d   = pix_cnt_q;
        dout_d      = dout_q;
        dvalid_d    = 1'b0;
        pix_idx_d   = pix_idx_q;
        busy_d      = busy_q;
        done_d      = zero_pend_q;
        zero_pend_d = 1'b0;
        clip_d      = clip_q;

        sample_ext = fmt_q ? ACC_W'($signed(conv)) : ACC_W'(conv);
        sum        = acc_q + sample_ext;
        sum_s      = sum;
        if (fmt_q) begin
            shifted = sum_s >>> avg_q;
        end else begin
            shifted = sum >> avg_q;
        end
        win_max = CNT_W'((32'(1) << avg_q) - 1);

        case (state_q)
            IDLE: begin
                if (line_start_i) begin
                    fmt_d     = fmt_signed_i;
                    len_d     = line_len_i;
                    avg_d     = AVG_W'(clamp_avg(32'(avg_log2_i), AVG_MAX_LOG2));
                    acc_d     = '0;
                    cnt_d     = '0;
                    pix_cnt_d = '0;
                    clip_d    = 1'b0;
                    if (line_len_i != '0) begin
                        busy_d  = 1'b1;
                        state_d = ACTIVE;
                    end else begin
                        zero_pend_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (raw_clip) begin
                    clip_d = 1'b1;
                end
                if (cnt_q == win_max) begin
                    dout_d    = shifted[DATA_W-1:0];
                    dvalid_d  = 1'b1;
                    pix_idx_d = pix_cnt_q;
                    pix_cnt_d = pix_cnt_q + PIX_W'(1);
                    acc_d     = '0;
                    cnt_d     = '0;
                    if (pix_cnt_q == len_q - PIX_W'(1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout_o      = dout_q;
    assign dvalid_o    = dvalid_q;
    assign pix_idx_o   = pix_idx_q;
    assign line_busy_o = busy_q;
    assign line_done_o = done_q;
    assign clip_o      = clip_q;

endmodule

// File: doc/adc_line_capture.md
Name: adc_line_capture

Overview:
Parametrised ADC front end for the line scanner, running in the ADC clock domain.
- Registers ADC pins in the IOB and converts offset-binary to two's complement when configured.
- Optionally box-car averages 2^k consecutive samples per pixel, selectable at run time.
- Frames a line of LINE_LEN pixels and emits one valid-strobed pixel per average window, with pixel index, end-of-line pulse and clip flag for the downstream line buffer.

Parameters:
DATA_W, 12, ADC sample width in bits.
AVG_MAX_LOG2, 3, maximum averaging exponent; window = 2^AVG_LOG2 samples.
PIX_W, 12, width of pixel index and line length.

Ports:
ADC_CLK  in  1  sole clock; all logic on rising edge.
RST  in  1  reset, synchronous, active-high.
ADC_DATA  in  DATA_W  raw ADC output bus.
FMT_SIGNED  in  1  1: invert MSB (offset-binary to two's complement); 0: pass unchanged.
AVG_LOG2  in  $clog2(AVG_MAX_LOG2+1)  averaging exponent request.
LINE_LEN  in  PIX_W  pixels per line.
LINE_START  in  1  single-cycle request to start a line.
DOUT  out  DATA_W  averaged pixel value.
DVALID  out  1  one-cycle strobe; DOUT/PIX_IDX valid.
PIX_IDX  out  PIX_W  index of current DOUT pixel, 0-based.
LINE_BUSY  out  1  high while a line is being captured.
LINE_DONE  out  1  one-cycle end-of-line pulse.
CLIP  out  1  sticky: a raw sample in the current/last line was all-zeros or all-ones.

Behaviour:
- Reset: all registers cleared. DOUT=0, DVALID=0, PIX_IDX=0, LINE_BUSY=0, LINE_DONE=0, CLIP=0, state IDLE. Reset mid-line aborts the line; no LINE_DONE is issued.
- Input pipeline, free-running, not gated by state:
  - r_iob <= ADC_DATA.
  - r_conv <= r_iob XOR (FMT_SIGNED ? 1<<(DATA_W-1) : 0).
  - r_raw_clip <= (r_iob == 0) or (r_iob == all-ones).
- States: IDLE, ACTIVE.
- IDLE:
  - LINE_START=1 at edge t latches FMT_SIGNED, LINE_LEN and AVG_LOG2 (clamped to AVG_MAX_LOG2). It also clears the accumulator, sample count, pixel count and CLIP.
  - If LINE_LEN != 0: LINE_BUSY=1 from edge t and state goes to ACTIVE.
  - If LINE_LEN == 0: LINE_DONE pulses at edge t+1, no DVALID, and the block stays IDLE.
- ACTIVE: each edge from t+1 consumes the current r_conv, so the first sample is the ADC_DATA value captured at edge t-1.
  - Accumulator width: DATA_W+AVG_MAX_LOG2. Samples are sign-extended if the latched FMT_SIGNED=1, else zero-extended.
  - On the last sample of a window (count == 2^AVG_LOG2 - 1), at the same edge:
    - DOUT <= (acc + sample) shifted right by AVG_LOG2. Shift is arithmetic if signed, logical if unsigned; floor rounding.
    - DVALID=1, PIX_IDX <= pixel count.
    - Pixel count increments; accumulator and sample count clear.
  - If that pixel is LINE_LEN-1, LINE_DONE=1 at the same edge as the final DVALID, LINE_BUSY=0 at the same edge, and state returns to IDLE.
- Latency: AVG_LOG2=0 gives DOUT at edge e equal to the conversion of ADC_DATA captured at edge e-2. Throughput is one pixel per 2^AVG_LOG2 cycles.
- CLIP: set when r_raw_clip=1 on a consumed sample. Holds until the next accepted LINE_START or reset.
- LINE_START while ACTIVE is ignored. Changes to FMT_SIGNED, AVG_LOG2 or LINE_LEN mid-line are ignored.
- DOUT and PIX_IDX hold their last values between strobes. LINE_START coincident with LINE_DONE is ignored because the state is not yet IDLE; the next line may start one cycle later.

Decomposition:
- Package adc_pkg: state encoding (IDLE, ACTIVE), MSB-invert mask function, and clamp helper for AVG_LOG2.
- Sub-module adc_fmt_stage: IOB register, format conversion and raw clip detection, DATA_W parametrised.
- Framing, accumulation and the FSM stay in adc_line_capture.

Test Plan:
- AVG_LOG2=0, FMT_SIGNED=1, LINE_LEN=4, raw 0x800,0xFFF,0x000,0x7FF -> DOUT 0x000,0x7FF,0x800,0xFFF on consecutive cycles; PIX_IDX 0..3; LINE_DONE with the 4th DVALID; CLIP=1.
- AVG_LOG2=2, FMT_SIGNED=0, LINE_LEN=2, raw 10,20,30,40,1,2,3,4 -> DVALID every 4 cycles; DOUT 25 then 2; CLIP=0.
- AVG_LOG2=2, FMT_SIGNED=1, raw 0x7FF,0x7FF,0x7FE,0x7FE (-1,-1,-2,-2) -> DOUT 0xFFE (-2, floor of -1.5).
- LINE_LEN=0 -> LINE_DONE pulse at t+1, LINE_BUSY stays 0, no DVALID. AVG_LOG2 request of 7 -> behaves as 3.
- LINE_START and new AVG_LOG2/LINE_LEN values during an active line -> ignored; the line finishes with the latched settings.
- RST mid-line after 2 of 8 pixels -> all outputs 0, no LINE_DONE; a new LINE_START afterwards restarts at PIX_IDX=0.
